// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader_pkg
// Description : Shared state encoding and constants for the ROM image loader.
// Revision    : 1.0  initial release
// ============================================================================
package rom_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FILL  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage : rom_loader_pkg
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader
// Description : Streams a byte image into a KB-kilobyte ROM write port, pads
//               short images with 0xFF and reports an 8-bit running checksum.
// Revision    : 1.0  initial release
// ============================================================================
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int  KB = 16,
    localparam int N  = KB * 1024,
    localparam int AW = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic [AW-1:0] a,
    output logic [7:0]    d,
    output logic          w,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [7:0]    sum
);

    localparam logic [AW:0] LAST_ADDR = (AW + 1)'(N - 1);
    localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);

    state_t        state_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic [7:0]    sum_q;
    logic [7:0]    sum_d;
    logic [AW-1:0] a_q;
    logic [7:0]    d_q;
    logic          w_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;

    always_comb begin
        cnt_d = cnt_q + CNT_ONE;
        sum_d = sum_q + s_data;
    end

    // done/error/busy settle one edge after the final write so the last write
    // cycle is still covered by busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            a_q     <= '0;
            d_q     <= '0;
            w_q     <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            w_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: begin
                    busy_q  <= 1'b0;
                    done_q  <= (state_q == DONE);
                    error_q <= (state_q == ERROR);
                    if (start) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        a_q   <= cnt_q[AW-1:0];
                        d_q   <= s_data;
                        w_q   <= 1'b1;
                        cnt_q <= cnt_d;
                        sum_q <= sum_d;
                        if (cnt_q == LAST_ADDR) begin
                            ready_q <= 1'b0;
                            state_q <= s_last ? DONE : ERROR;
                        end else if (s_last) begin
                            ready_q <= 1'b0;
                            state_q <= FILL;
                        end
                    end
                end
                FILL: begin
                    a_q   <= cnt_q[AW-1:0];
                    d_q   <= FILL_BYTE;
                    w_q   <= 1'b1;
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready = ready_q;
    assign a       = a_q;
    assign d       = d_q;
    assign w       = w_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
    assign sum     = sum_q;

endmodule : rom_loader
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_loader
// Description : Scoreboard bench for rom_loader with KB=1 (N=1024).
// Revision    : 1.0  initial release
// ============================================================================
module tb_rom_loader;

    localparam int N = 1024;

    typedef struct {
        logic [9:0] a;
        logic [7:0] d;
        int         c;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [9:0] a;
    logic [7:0] d;
    logic       w;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] sum;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         exp_a = 0;
    int         last_acc = 0;
    logic [7:0] sum_m = 8'h00;
    exp_t       exp_q[$];

    rom_loader #(.KB(1)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .a       (a),
        .d       (d),
        .w       (w),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .sum     (sum)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    // Write monitor: every strobe must match the oldest expected write, cycle included.
    always @(negedge clock) begin
        if (w === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected actual a=%0h d=%0h cyc=%0d required no write", a, d, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (a !== e.a || d !== e.d || cyc != e.c) begin
                    errors++;
                    $display("FAIL wr actual a=%0h d=%0h cyc=%0d required a=%0h d=%0h cyc=%0d",
                             a, d, cyc, e.a, e.d, e.c);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        exp_a = 0;
        sum_m = 8'h00;
        @(negedge clock);
        start = 1'b0;
        chk("start_ready", 32'(s_ready), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_sum", 32'(sum), 32'd0);
    endtask

    task automatic send(input logic [7:0] b, input logic last, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clock);
        @(negedge clock);
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        while (s_ready !== 1'b1 && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (s_ready !== 1'b1) begin
            chk("accept_timeout", 32'(s_ready), 32'd1);
        end else begin
            last_acc = cyc + 1;
            exp_q.push_back('{a: 10'(exp_a), d: b, c: last_acc});
            exp_a++;
            sum_m = sum_m + b;
        end
        @(posedge clock);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Pushes the expected 0xFF padding, then checks the completion handshake.
    task automatic finish_load(input logic exp_err, input logic pulse_start);
        int n;
        int target;
        int t;
        n = exp_err ? 0 : N - exp_a;
        for (int i = 0; i < n; i++)
            exp_q.push_back('{a: 10'(exp_a + i), d: 8'hFF, c: last_acc + 1 + i});
        target = last_acc + n;
        if (pulse_start) begin
            repeat (10) @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        @(negedge clock);
        t = 0;
        while (cyc < target && t < 2000) begin
            @(negedge clock);
            t++;
        end
        chk("final_wr_busy", 32'(busy), 32'd1);
        chk("final_wr_done", 32'(done), 32'd0);
        chk("final_wr_error", 32'(error), 32'd0);
        @(negedge clock);
        chk("end_done", 32'(done), 32'(!exp_err));
        chk("end_error", 32'(error), 32'(exp_err));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ready", 32'(s_ready), 32'd0);
        chk("end_sum", 32'(sum), 32'(sum_m));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_w", 32'(w), 32'd0);
        chk("rst_outs", {busy, done, error, s_ready}, 32'd0);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        reset = 1'b0;

        // Exact-size load: bytes i[7:0], sum wraps to 0x00
        do_start();
        for (int i = 0; i < N; i++) send(8'(i), i == N - 1, 0);
        finish_load(1'b0, 1'b0);
        chk("exact_sum_const", 32'(sum), 32'h00);

        // Overflow: no s_last
        do_start();
        for (int i = 0; i < N; i++) send(8'(i), 1'b0, 0);
        finish_load(1'b1, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h77;
        repeat (4) begin
            @(negedge clock);
            chk("ovf_no_w", 32'(w), 32'd0);
            chk("ovf_ready", 32'(s_ready), 32'd0);
        end
        s_valid = 1'b0;
        chk("ovf_done", 32'(done), 32'd0);

        // Backpressure gaps
        do_start();
        send(8'hAA, 1'b0, 0);
        send(8'h55, 1'b0, 2);
        send(8'h0F, 1'b0, 2);
        send(8'hF0, 1'b1, 2);
        finish_load(1'b0, 1'b0);
        chk("gap_sum_const", 32'(sum), 32'hFE);

        // Reset mid-load while the 100th write is on the bus
        do_start();
        for (int i = 0; i < 100; i++) send(8'(i * 3), 1'b0, 0);
        chk("pre_rst_w", 32'(w), 32'd1);
        void'(exp_q.pop_back());
        reset = 1'b1;
        #1;
        chk("midrst_w", 32'(w), 32'd0);
        chk("midrst_outs", {busy, done, error, s_ready}, 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Short load with fill, start pulsed during FILL is ignored
        do_start();
        send(8'h01, 1'b0, 0);
        send(8'h02, 1'b0, 0);
        send(8'h03, 1'b1, 0);
        finish_load(1'b0, 1'b1);
        chk("short_sum_const", 32'(sum), 32'h06);

        // Start from DONE clears done and sum
        do_start();
        chk("restart_error", 32'(error), 32'd0);
        send(8'h5A, 1'b1, 0);
        finish_load(1'b0, 1'b0);
        chk("restart_sum_const", 32'(sum), 32'h5A);

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rom_loader
`default_nettype wire
